// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel state
// encoding, board timing defaults and shortened simulation timings.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } chan_state_e;

   // 50 MHz board: 20 ms debounce, 1 s hold, 250 ms auto-repeat
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_HOLD_CYCLES     = 50000000;
   localparam int DEF_REPEAT_CYCLES   = 12500000;
   localparam int DEF_CNT_W           = 26;

   // Shortened timings so a simulation walks through every event quickly
   localparam int SIM_DEBOUNCE_CYCLES = 4;
   localparam int SIM_HOLD_CYCLES     = 10;
   localparam int SIM_REPEAT_CYCLES   = 3;

   // True when a cnt_w-bit counter can reach every terminal count
   function automatic bit cnt_w_fits(input int cnt_w, input int deb,
                                     input int hold, input int rep);
      longint lim;
      lim = longint'(1) << cnt_w;
      return (longint'(deb) < lim) && (longint'(hold) < lim) &&
             (longint'(rep) < lim);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce counter and the
// IDLE/PRESSED/HELD event FSM producing press/release/hold/repeat pulses.
//
// All event outputs are single-cycle pulses, registered, with no handshake:
// the consumer must sample them every cycle. A release accepted in the same
// cycle a hold or repeat would fire suppresses that hold/repeat.
module button_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       btn_n_in,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       hold_pulse,
   output logic       repeat_pulse,
   output logic [1:0] state
);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   // With repeat disabled the terminal value is never compared
   localparam logic [CNT_W-1:0] REP_LAST =
      (REPEAT_CYCLES == 0) ? '0 : CNT_W'(REPEAT_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             sync;
   logic [CNT_W-1:0] deb_cnt;
   logic             accept;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] rep_cnt;
   chan_state_e      st;

   // Two-flop synchroniser; resets to the released (high) pin level
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= btn_n_in;
         sync_2 <= sync_1;
      end
   end

   assign sync   = ~sync_2;
   // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample
   assign accept = (sync != btn_level) && (deb_cnt == DEB_LAST);

   // Debounce: count consecutive samples that disagree with the accepted level
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         deb_cnt   <= '0;
         btn_level <= 1'b0;
      end else if (sync == btn_level) begin
         deb_cnt <= '0;
      end else if (accept) begin
         deb_cnt   <= '0;
         btn_level <= sync;
      end else begin
         deb_cnt <= deb_cnt + CNT_ONE;
      end
   end

   // Channel FSM with registered event pulses; release has priority
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         st            <= ST_IDLE;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         hold_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         hold_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (accept && sync) begin
                  press_pulse <= 1'b1;
                  hold_cnt    <= '0;
                  st          <= ST_PRESSED;
               end
            end
            ST_PRESSED: begin
               if (accept && !sync) begin
                  release_pulse <= 1'b1;
                  st            <= ST_IDLE;
               end else if (hold_cnt == HOLD_LAST) begin
                  hold_pulse <= 1'b1;
                  rep_cnt    <= '0;
                  st         <= ST_HELD;
               end else begin
                  hold_cnt <= hold_cnt + CNT_ONE;
               end
            end
            ST_HELD: begin
               if (accept && !sync) begin
                  release_pulse <= 1'b1;
                  st            <= ST_IDLE;
               end else if (REPEAT_CYCLES != 0) begin
                  if (rep_cnt == REP_LAST) begin
                     repeat_pulse <= 1'b1;
                     rep_cnt      <= '0;
                  end else begin
                     rep_cnt <= rep_cnt + CNT_ONE;
                  end
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign state = st;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BTN independent conditioned channels.
// chan_state exposes each channel FSM state (2 bits per channel, channel 0
// in the low bits) for observation.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [NUM_BTN-1:0]   btn_n_in,
   output logic [NUM_BTN-1:0]   btn_level,
   output logic [NUM_BTN-1:0]   press_pulse,
   output logic [NUM_BTN-1:0]   release_pulse,
   output logic [NUM_BTN-1:0]   hold_pulse,
   output logic [NUM_BTN-1:0]   repeat_pulse,
   output logic [2*NUM_BTN-1:0] chan_state
);

   // Refuse to build with counters too narrow or timings out of range
   if (!cnt_w_fits(CNT_W, DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) begin : g_bad_cnt_w
      $error("button_conditioner: CNT_W too narrow for the configured timings");
   end
   if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 0) begin : g_bad_timing
      $error("button_conditioner: timing parameters out of range");
   end

   // One fully independent channel per button
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .CNT_W           (CNT_W)
      ) u_chan (
         .CLK           (CLK),
         .RST_N         (RST_N),
         .btn_n_in      (btn_n_in[i]),
         .btn_level     (btn_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .hold_pulse    (hold_pulse[i]),
         .repeat_pulse  (repeat_pulse[i]),
         .state         (chan_state[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two builds (repeat every 3 cycles, and repeat
// disabled) driven from the same pins, checked every cycle against a
// timeline model, plus literal timing expectations for the directed cases.
module tb_button_conditioner;
   import btn_pkg::*;

   localparam int NB   = 3;
   localparam int DEB  = SIM_DEBOUNCE_CYCLES;
   localparam int HOLD = SIM_HOLD_CYCLES;
   localparam int REP  = SIM_REPEAT_CYCLES;

   // ---------------- clock / reset ----------------
   logic          CLK   = 1'b0;
   logic          RST_N = 1'b0;
   logic [NB-1:0] btn_n = '1;
   int            cyc   = 0;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // index 0: REPEAT_CYCLES=3 build, index 1: REPEAT_CYCLES=0 build
   logic [NB-1:0]   o_lvl[2];
   logic [NB-1:0]   o_prs[2];
   logic [NB-1:0]   o_rel[2];
   logic [NB-1:0]   o_hld[2];
   logic [NB-1:0]   o_rep[2];
   logic [2*NB-1:0] o_st[2];

   button_conditioner #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP), .CNT_W(8)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .btn_n_in(btn_n),
      .btn_level(o_lvl[0]), .press_pulse(o_prs[0]), .release_pulse(o_rel[0]),
      .hold_pulse(o_hld[0]), .repeat_pulse(o_rep[0]), .chan_state(o_st[0])
   );

   button_conditioner #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(0), .CNT_W(8)
   ) dut_norep (
      .CLK(CLK), .RST_N(RST_N), .btn_n_in(btn_n),
      .btn_level(o_lvl[1]), .press_pulse(o_prs[1]), .release_pulse(o_rel[1]),
      .hold_pulse(o_hld[1]), .repeat_pulse(o_rep[1]), .chan_state(o_st[1])
   );

   // ---------------- reference model ----------------
   // Pin samples give the pressed view two edges later; a level flips when the
   // last DEB pressed-view samples all disagree with it. Hold/repeat are
   // derived from the distance in cycles since the accepted press.
   int  rep_of[2] = '{REP, 0};
   bit  pinq[NB][$];
   bit  syncq[NB][$];
   bit  m_lvl[2][NB];
   bit  m_prs[2][NB];
   bit  m_rel[2][NB];
   bit  m_hld[2][NB];
   bit  m_rep[2][NB];
   int  m_st[2][NB];
   int  m_press_at[2][NB];

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int ch = 0; ch < NB; ch++) begin
            pinq[ch]  = '{1'b1, 1'b1};
            syncq[ch] = '{};
            for (int i = 0; i < 2; i++) begin
               m_lvl[i][ch] = 0; m_prs[i][ch] = 0; m_rel[i][ch] = 0;
               m_hld[i][ch] = 0; m_rep[i][ch] = 0; m_st[i][ch] = ST_IDLE;
               m_press_at[i][ch] = 0;
            end
         end
      end else begin
         for (int ch = 0; ch < NB; ch++) begin
            bit x;
            pinq[ch].push_back(btn_n[ch]);
            x = !pinq[ch][0];
            void'(pinq[ch].pop_front());
            syncq[ch].push_back(x);
            if (syncq[ch].size() > DEB) void'(syncq[ch].pop_front());
            for (int i = 0; i < 2; i++) begin
               bit all_diff;
               int d;
               m_prs[i][ch] = 0; m_rel[i][ch] = 0; m_hld[i][ch] = 0; m_rep[i][ch] = 0;
               all_diff = (syncq[ch].size() == DEB);
               for (int k = 0; k < syncq[ch].size(); k++)
                  if (syncq[ch][k] == m_lvl[i][ch]) all_diff = 0;
               if (all_diff) begin
                  m_lvl[i][ch] = x;
                  if (x) begin
                     m_prs[i][ch] = 1;
                     m_press_at[i][ch] = cyc;
                  end else begin
                     m_rel[i][ch] = 1;
                  end
               end
               d = cyc - m_press_at[i][ch];
               if (!all_diff && m_lvl[i][ch]) begin
                  m_hld[i][ch] = (d == HOLD);
                  m_rep[i][ch] = (rep_of[i] != 0) && (d > HOLD) &&
                                 ((d - HOLD) % rep_of[i] == 0);
               end
               if (!m_lvl[i][ch])  m_st[i][ch] = ST_IDLE;
               else if (d < HOLD)  m_st[i][ch] = ST_PRESSED;
               else                m_st[i][ch] = ST_HELD;
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   int prs_cnt[2][NB], rel_cnt[2][NB], hld_cnt[2][NB], rep_cnt[2][NB];
   int prs_at[2][NB], rel_at[2][NB], hld_at[2][NB];

   // Per-cycle compare of every output bit against the model, plus event log
   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         for (int ch = 0; ch < NB; ch++) begin
            chk($sformatf("lvl[%0d][%0d]", i, ch), int'(o_lvl[i][ch]), int'(m_lvl[i][ch]));
            chk($sformatf("press[%0d][%0d]", i, ch), int'(o_prs[i][ch]), int'(m_prs[i][ch]));
            chk($sformatf("release[%0d][%0d]", i, ch), int'(o_rel[i][ch]), int'(m_rel[i][ch]));
            chk($sformatf("hold[%0d][%0d]", i, ch), int'(o_hld[i][ch]), int'(m_hld[i][ch]));
            chk($sformatf("repeat[%0d][%0d]", i, ch), int'(o_rep[i][ch]), int'(m_rep[i][ch]));
            chk($sformatf("state[%0d][%0d]", i, ch), int'(o_st[i][2*ch +: 2]), m_st[i][ch]);
            if (o_prs[i][ch] === 1'b1) begin prs_cnt[i][ch]++; prs_at[i][ch] = cyc; end
            if (o_rel[i][ch] === 1'b1) begin rel_cnt[i][ch]++; rel_at[i][ch] = cyc; end
            if (o_hld[i][ch] === 1'b1) begin hld_cnt[i][ch]++; hld_at[i][ch] = cyc; end
            if (o_rep[i][ch] === 1'b1) rep_cnt[i][ch]++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   int t0;
   int rel_before;

   initial begin
      step(3);
      chk("reset_level", int'(o_lvl[0]), 0);
      RST_N = 1'b1;
      step(2);

      // 1: clean press and release on btn 0; release lands exactly when the
      //    hold would fire, so no hold_pulse
      t0 = cyc;
      btn_n[0] = 1'b0;
      step(10);
      chk("t1_press_latency", prs_at[0][0] - t0, 6);
      chk("t1_press_count", prs_cnt[0][0], 1);
      t0 = cyc;
      btn_n[0] = 1'b1;
      step(10);
      chk("t1_release_latency", rel_at[0][0] - t0, 6);
      chk("t1_release_count", rel_cnt[0][0], 1);
      chk("t1_no_hold", hld_cnt[0][0], 0);

      // 2: 3-cycle glitch on btn 1 is ignored, 4-cycle low is accepted
      btn_n[1] = 1'b0; step(3); btn_n[1] = 1'b1; step(10);
      chk("t2_glitch_press", prs_cnt[0][1], 0);
      chk("t2_glitch_level", int'(o_lvl[0][1]), 0);
      btn_n[1] = 1'b0; step(4); btn_n[1] = 1'b1; step(12);
      chk("t2_short_press", prs_cnt[0][1], 1);
      chk("t2_short_release", rel_cnt[0][1], 1);

      // 3/4: btn 2 level held 30 cycles after press_pulse
      t0 = cyc;
      btn_n[2] = 1'b0;
      step(30);
      btn_n[2] = 1'b1;
      step(12);
      chk("t3_press_latency", prs_at[0][2] - t0, 6);
      chk("t3_hold_delay", hld_at[0][2] - prs_at[0][2], 10);
      chk("t3_hold_count", hld_cnt[0][2], 1);
      chk("t3_repeat_count", rep_cnt[0][2], 6);
      chk("t3_release_delay", rel_at[0][2] - prs_at[0][2], 30);
      chk("t4_norep_hold", hld_cnt[1][2], 1);
      chk("t4_norep_repeat", rep_cnt[1][2], 0);

      // 5: simultaneous presses on btn 0 and btn 2
      btn_n[0] = 1'b0; btn_n[2] = 1'b0;
      step(10);
      chk("t5_same_cycle", prs_at[0][0] - prs_at[0][2], 0);
      chk("t5_btn0_count", prs_cnt[0][0], 2);
      chk("t5_btn2_count", prs_cnt[0][2], 2);
      btn_n[0] = 1'b1; btn_n[2] = 1'b1;
      step(10);

      // 6: reset while btn 0 is HELD, button still down after reset
      btn_n[0] = 1'b0;
      step(20);
      chk("t6_held_before_reset", int'(o_st[0][1:0]), int'(ST_HELD));
      rel_before = rel_cnt[0][0];
      RST_N = 1'b0;
      #1;
      chk("t6_async_clear_level", int'(o_lvl[0]), 0);
      chk("t6_async_clear_state", int'(o_st[0]), 0);
      step(3);
      RST_N = 1'b1;
      t0 = cyc;
      step(10);
      chk("t6_fresh_press_latency", prs_at[0][0] - t0, 6);
      chk("t6_no_release", rel_cnt[0][0], rel_before);
      btn_n[0] = 1'b1;
      step(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
